// File: rtl/gcd_subtractor.sv
// Free-running subtraction GCD engine: one compare/subtract per clock,
// recomputes automatically whenever the operands differ from the last capture.
module gcd_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [WIDTH-1:0] xr, xr_n;
    logic [WIDTH-1:0] yr, yr_n;
    logic [WIDTH-1:0] result_n;
    logic             done_n;
    logic             busy_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= LOAD;
            a      <= '0;
            b      <= '0;
            xr     <= '0;
            yr     <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            b      <= b_n;
            xr     <= xr_n;
            yr     <= yr_n;
            result <= result_n;
            done   <= done_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a;
        b_n      = b;
        xr_n     = xr;
        yr_n     = yr;
        result_n = result;
        done_n   = 1'b0;
        busy_n   = busy;
        unique case (state)
            LOAD: begin
                a_n     = x;
                b_n     = y;
                xr_n    = x;
                yr_n    = y;
                busy_n  = 1'b1;
                state_n = CALC;
            end
            CALC: begin
                // Zero and equal operands finish here without subtracting.
                if (a == '0) begin
                    result_n = b;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = DONE;
                end else if (b == '0 || a == b) begin
                    result_n = a;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = DONE;
                end else if (a > b) begin
                    a_n = a - b;
                end else begin
                    b_n = b - a;
                end
            end
            DONE: begin
                if (x != xr || y != yr) begin
                    state_n = LOAD;
                    busy_n  = 1'b1;
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_subtractor.sv
// Directed bench for gcd_subtractor: latency, held result, recompute, reset abort.
module tb_gcd_subtractor;

    logic       clk;
    logic       reset;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] result;
    logic       done;
    logic       busy;

    int checks;
    int failures;

    gcd_subtractor #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .y      (y),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset with new operands, check reset values, release mid-cycle.
    task automatic restart(input string tag, input logic [3:0] xv,
                           input logic [3:0] yv);
        #2;
        x     = xv;
        y     = yv;
        reset = 1'b0;
        #1;
        chk({tag, "_rst_result"}, 32'(result), 0);
        chk({tag, "_rst_done"}, 32'(done), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Count edges until done; result must hold and busy stay high meanwhile.
    task automatic measure(input string tag, input int exp_edges,
                           input int exp_res, input int held);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            n = k;
            if (done) begin
                got = 1'b1;
                break;
            end
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_held"}, 32'(result), 32'(held));
        end
        chk({tag, "_edges"}, got ? 32'(n) : 32'hffffffff, 32'(exp_edges));
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_busy_lo"}, 32'(busy), 0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        x        = '0;
        y        = '0;

        restart("g12_15", 4'd12, 4'd15);
        measure("g12_15", 6, 3, 0);

        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_result", 32'(result), 3);
            chk("idle_done", 32'(done), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        x = 4'd12;
        y = 4'd4;
        step();
        chk("chg_busy", 32'(busy), 1);
        chk("chg_done", 32'(done), 0);
        chk("chg_result", 32'(result), 3);
        measure("g12_4", 4, 4, 3);

        restart("g7_7", 4'd7, 4'd7);
        measure("g7_7", 2, 7, 0);
        restart("g0_9", 4'd0, 4'd9);
        measure("g0_9", 2, 9, 0);
        restart("g9_0", 4'd9, 4'd0);
        measure("g9_0", 2, 9, 0);
        restart("g0_0", 4'd0, 4'd0);
        measure("g0_0", 2, 0, 0);
        restart("g15_1", 4'd15, 4'd1);
        measure("g15_1", 16, 1, 0);

        restart("mid", 4'd12, 4'd15);
        step();
        step();
        x = 4'd9;
        measure("mid_first", 4, 3, 0);
        measure("mid_second", 5, 3, 3);

        x = 4'd15;
        y = 4'd1;
        for (int k = 0; k < 5; k++) step();
        chk("abort_busy_pre", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_result", 32'(result), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        measure("abort_restart", 16, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
